// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a 1R1W sync-read memory between
// clients A and B, with read-after-write stall and tagged read return.
module mem_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  a_wr_req,
  input  logic [ADDR_WIDTH-1:0] a_wr_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic                  a_wr_gnt,
  input  logic                  a_rd_req,
  input  logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic                  a_rd_gnt,
  output logic                  a_rd_valid,

  input  logic                  b_wr_req,
  input  logic [ADDR_WIDTH-1:0] b_wr_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic                  b_wr_gnt,
  input  logic                  b_rd_req,
  input  logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic                  b_rd_gnt,
  output logic                  b_rd_valid,

  output logic [DATA_WIDTH-1:0] rd_data,

  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic {
    CL_A = 1'b0,
    CL_B = 1'b1
  } client_e;

  client_e wr_rr;
  client_e rd_rr;
  client_e rd_owner;
  logic    rd_pend;

  logic                  wr_both;
  logic                  wr_any;
  logic                  wr_pick_b;
  logic                  wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;

  logic                  rd_both;
  logic                  rd_any;
  logic                  rd_pick_b;
  logic                  rd_go;
  logic                  hazard;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;

  // Write port decision: pointer only matters when both ask.
  always_comb begin
    wr_both     = a_wr_req & b_wr_req;
    wr_any      = a_wr_req | b_wr_req;
    wr_pick_b   = wr_both ? (wr_rr == CL_B) : b_wr_req;
    wr_go       = wr_any & rst_n;
    wr_addr_sel = wr_pick_b ? b_wr_addr : a_wr_addr;
    wr_data_sel = wr_pick_b ? b_wr_data : a_wr_data;
  end

  // Read port follows the write decision so a colliding read waits
  // one cycle and then sees the freshly written word.
  always_comb begin
    rd_both     = a_rd_req & b_rd_req;
    rd_any      = a_rd_req | b_rd_req;
    rd_pick_b   = rd_both ? (rd_rr == CL_B) : b_rd_req;
    rd_addr_sel = rd_pick_b ? b_rd_addr : a_rd_addr;
    hazard      = wr_go & rd_any & (rd_addr_sel == wr_addr_sel);
    rd_go       = rd_any & rst_n & ~hazard;
  end

  always_comb begin
    a_wr_gnt    = wr_go & ~wr_pick_b;
    b_wr_gnt    = wr_go & wr_pick_b;
    a_rd_gnt    = rd_go & ~rd_pick_b;
    b_rd_gnt    = rd_go & rd_pick_b;
    mem_wr_en   = wr_go;
    mem_wr_addr = wr_addr_sel;
    mem_wr_data = wr_data_sel;
    mem_rd_en   = rd_go;
    mem_rd_addr = rd_addr_sel;
    rd_data     = mem_rd_data;
    a_rd_valid  = rd_pend & (rd_owner == CL_A);
    b_rd_valid  = rd_pend & (rd_owner == CL_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_rr    <= CL_A;
      rd_rr    <= CL_A;
      rd_pend  <= 1'b0;
      rd_owner <= CL_A;
    end else begin
      if (wr_go && wr_both) begin
        wr_rr <= wr_pick_b ? CL_A : CL_B;
      end
      if (rd_go && rd_both) begin
        rd_rr <= rd_pick_b ? CL_A : CL_B;
      end
      rd_pend <= rd_go;
      if (rd_go) begin
        rd_owner <= rd_pick_b ? CL_B : CL_A;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycles with expected grants; read returns
// are scoreboarded against a reference copy of the memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_wr_req, b_wr_req, a_rd_req, b_rd_req;
  logic [1:0] a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
  logic [3:0] a_wr_data, b_wr_data;
  logic       a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt;
  logic       a_rd_valid, b_rd_valid;
  logic [3:0] rd_data;
  logic       mem_wr_en, mem_rd_en;
  logic [1:0] mem_wr_addr, mem_rd_addr;
  logic [3:0] mem_wr_data;
  logic [3:0] mem_rd_data = 4'd0;

  logic [3:0] mem     [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] ref_mem [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  typedef struct {
    logic       owner;
    logic [3:0] data;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .a_wr_gnt(a_wr_gnt), .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr),
    .a_rd_gnt(a_rd_gnt), .a_rd_valid(a_rd_valid),
    .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .b_wr_gnt(b_wr_gnt), .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr),
    .b_rd_gnt(b_rd_gnt), .b_rd_valid(b_rd_valid),
    .rd_data(rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_valid();
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_valid", 8'({a_rd_valid, b_rd_valid}),
          e.owner ? 8'd1 : 8'd2);
      chk("rd_data", 8'(rd_data), 8'(e.data));
    end else begin
      chk("no_valid", 8'({a_rd_valid, b_rd_valid}), 8'd0);
    end
  endtask

  // eg = expected {a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}
  task automatic step(
    input logic aw, input logic [1:0] awa, input logic [3:0] awd,
    input logic bw, input logic [1:0] bwa, input logic [3:0] bwd,
    input logic ar, input logic [1:0] ara,
    input logic br, input logic [1:0] bra,
    input logic [3:0] eg);
    logic [1:0] ra;
    a_wr_req = aw; a_wr_addr = awa; a_wr_data = awd;
    b_wr_req = bw; b_wr_addr = bwa; b_wr_data = bwd;
    a_rd_req = ar; a_rd_addr = ara;
    b_rd_req = br; b_rd_addr = bra;
    @(negedge clk);
    check_valid();
    chk("gnt", 8'({a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}), 8'(eg));
    chk("mem_wr_en", 8'(mem_wr_en), 8'(eg[3] | eg[2]));
    if (eg[3] | eg[2])
      chk("mem_wr", 8'({mem_wr_addr, mem_wr_data}),
          eg[3] ? 8'({awa, awd}) : 8'({bwa, bwd}));
    chk("mem_rd_en", 8'(mem_rd_en), 8'(eg[1] | eg[0]));
    if (eg[1] | eg[0]) begin
      ra = eg[1] ? ara : bra;
      chk("mem_rd_addr", 8'(mem_rd_addr), 8'(ra));
      sb.push_back('{owner: eg[0], data: ref_mem[ra]});
    end
    if (eg[3]) ref_mem[awa] = awd;
    else if (eg[2]) ref_mem[bwa] = bwd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", 8'({a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}), 8'd0);
    chk("rst_mem_en", 8'({mem_wr_en, mem_rd_en}), 8'd0);
    chk("rst_valid", 8'({a_rd_valid, b_rd_valid}), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_wr_req = 1'b1; a_wr_addr = 2'd0; a_wr_data = 4'd1;
    b_wr_req = 1'b1; b_wr_addr = 2'd1; b_wr_data = 4'd2;
    a_rd_req = 1'b1; a_rd_addr = 2'd2;
    b_rd_req = 1'b1; b_rd_addr = 2'd3;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // contended start: A first on both ports, then B
    step(1, 0, 1, 1, 1, 2, 1, 2, 1, 3, 4'b1010);
    step(1, 0, 1, 1, 1, 2, 1, 2, 1, 3, 4'b0101);

    // lone write then read back
    step(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 4'b0010);

    // contended writes, A then B
    step(1, 1, 15, 1, 3, 9, 0, 0, 0, 0, 4'b1000);
    step(0, 0, 0, 1, 3, 9, 0, 0, 0, 0, 4'b0100);

    // same-address write stalls the read one cycle
    step(0, 0, 0, 1, 3, 7, 1, 3, 0, 0, 4'b0100);
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 4'b0010);

    // independent write and read in the same cycle
    step(1, 0, 5, 0, 0, 0, 0, 0, 1, 1, 4'b1001);

    // continuous contended reads alternate
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 0, 0, 0, 1, 0, 1, 3,
           (i % 2 == 1) ? 4'b0001 : 4'b0010);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 4'b0010);

    // reset with a read in flight
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 4'b0010);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
